imem_fetch_ctrl: RTL
====================

# imem_fetch_ctrl

Instruction-fetch controller for the pipelined datapath. Owns the program counter, drives the address of the asynchronous-read instruction memory, and registers the returned word into the IF/ID pipeline register. Handles hazard-unit stalls, branch/jump redirects with flush, wrap-around, and halt detection. Sits between the instruction memory and the decode stage.

## Interface
- addWidth, 6, instruction-memory address width (word addressed; depth 2**addWidth)
- dataWidth, 32, instruction width
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  one-cycle pulse: begin fetching at start_addr (honoured in IDLE or HALTED only)
- start_addr  in  addWidth  first fetch address
- stall  in  1  hazard unit: hold PC and IF/ID
- redirect  in  1  branch/jump taken: load PC, flush IF/ID
- redirect_addr  in  addWidth  redirect target
- imem_addr  out  addWidth  to instruction memory address port
- imem_data  in  dataWidth  from instruction memory data port (same-cycle combinational read)
- if_instr  out  dataWidth  IF/ID instruction
- if_pc  out  addWidth  IF/ID address of if_instr
- if_pc_plus1  out  addWidth  IF/ID if_pc+1 modulo 2**addWidth
- if_valid  out  1  IF/ID contents are a real instruction
- busy  out  1  high in RUN
- halted  out  1  high in HALTED
- instr_count  out  16  count of instructions delivered to IF/ID (if_valid rising into a new word)

## Operation
- States: IDLE, RUN, HALTED. Reset -> IDLE.
- Reset values: pc=0, imem_addr=0, if_instr=0, if_pc=0, if_pc_plus1=0, if_valid=0, busy=0, halted=0, instr_count=0.
- imem_addr = pc at all times (registered PC, combinational output).
- IDLE: no fetch, if_valid=0. start -> pc<=start_addr, RUN.
- RUN, per cycle, priority high to low:
  - redirect: pc<=redirect_addr; if_valid<=0 (flush); other IF/ID fields don't-care-held. Overrides stall and halt detection.
  - stall: pc, IF/ID, instr_count all hold.
  - imem_data==HALT_WORD: pc holds, if_valid<=0, -> HALTED. Halt word never enters IF/ID.
  - otherwise: if_instr<=imem_data, if_pc<=pc, if_pc_plus1<=pc+1, if_valid<=1, pc<=pc+1, instr_count<=instr_count+1.
- start in RUN: ignored.
- HALTED: pc holds, if_valid=0; start -> pc<=start_addr, RUN; redirect ignored.
- PC arithmetic: modulo 2**addWidth; pc=2**addWidth-1 increments to 0, no error.
- instr_count wraps 16'hFFFF -> 0.
- reset mid-run: next edge returns to reset values regardless of stall/redirect/start.

## Timing
- Start pulse in cycle t: pc=start_addr during t+1; first if_valid=1 visible in t+2.
- Steady state: one instruction per cycle into IF/ID; fetch-to-IF/ID latency 1 edge.
- Redirect in cycle t: if_valid=0 in t+1, target instruction valid in t+2 (one-bubble penalty).
- Stall held N cycles: IF/ID and imem_addr constant for those N cycles; resumes on first cycle stall=0.
- Halt word at pc in cycle t: halted=1, busy=0 from t+1; last valid IF/ID word (from t-1) replaced by bubble at t+1.
- busy/halted are registered state decodes, no combinational path from inputs.

## Test plan
- Reset then start with start_addr=0, memory words 0..4 = distinct values, word 5=HALT_WORD -> if_pc 0..4 valid on cycles 2..6, halted=1 at cycle 7, instr_count=5.
- Redirect at pc=3 to 20 -> one bubble (if_valid=0), then if_pc=20, if_pc_plus1=21; words 3..19 never appear.
- Stall 3 cycles with redirect asserted on the 2nd stall cycle -> redirect wins: bubble next cycle, then fetch from redirect_addr; instr_count unchanged through stall.
- start_addr=62, no halt in 62,63,0 -> if_pc sequence 62,63,0; if_pc_plus1 for 63 is 0.
- HALT_WORD fetched same cycle as redirect -> no halt, fetch continues at redirect_addr; HALT_WORD under stall -> no halt until stall drops.
- Reset asserted mid-RUN with stall=1 -> all outputs at reset values next cycle; start ignored while busy, accepted again from HALTED.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: program counter, instruction-memory addressing and IF/ID register with stall, redirect and halt
module imem_fetch_ctrl #(
    parameter int addWidth = 6,
    parameter int dataWidth = 32,
    parameter logic [dataWidth-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [addWidth-1:0]  start_addr,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [addWidth-1:0]  redirect_addr,
    output logic [addWidth-1:0]  imem_addr,
    input  logic [dataWidth-1:0] imem_data,
    output logic [dataWidth-1:0] if_instr,
    output logic [addWidth-1:0]  if_pc,
    output logic [addWidth-1:0]  if_pc_plus1,
    output logic                 if_valid,
    output logic                 busy,
    output logic                 halted,
    output logic [15:0]          instr_count
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
    state_t state;
    logic [addWidth-1:0] pc;
    assign imem_addr = pc;
    // fetch sequencer: redirect beats stall, stall beats halt detection, otherwise latch the fetched word
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            if_instr    <= '0;
            if_pc       <= '0;
            if_pc_plus1 <= '0;
            if_valid    <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if_valid <= 1'b0;
                    if (start) begin
                        pc     <= start_addr;
                        state  <= RUN;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                    end
                end
                RUN: begin
                    if (redirect) begin
                        pc       <= redirect_addr;
                        if_valid <= 1'b0;
                    end else if (!stall) begin
                        if (imem_data == HALT_WORD) begin
                            if_valid <= 1'b0;
                            state    <= HALTED;
                            busy     <= 1'b0;
                            halted   <= 1'b1;
                        end else begin
                            if_instr    <= imem_data;
                            if_pc       <= pc;
                            if_pc_plus1 <= pc + 1'b1;
                            if_valid    <= 1'b1;
                            pc          <= pc + 1'b1;
                            instr_count <= instr_count + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
